econet_rx_frame_reader: RTL
===========================

Name: econet_rx_frame_reader

Overview:
System-side sequencer for the buffered Econet receiver. It waits for a good-frame indication, then reads the frame out of the circular receive buffer word by word and presents it as a byte stream with valid/ready handshake. It also clears the frame-valid flag, handles buffer wrap-around, and keeps drop/overrun status for the CPU. It sits between the receive buffer's sys_* port and the CPU-facing byte FIFO or register block.

Parameters:
BUF_BYTES, 512, receive buffer size in bytes (power of two)
CNT_WIDTH, 9, byte-counter width = log2(BUF_BYTES)
MAX_LEN, 256, frame lengths above this are dropped without streaming

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
frame_valid  in  1  good-frame flag from the buffer (econet_clk domain, level)
frame_start  in  32  byte index of first frame byte (low CNT_WIDTH bits used)
frame_end  in  32  byte index one past last byte (low CNT_WIDTH bits used)
buf_select  out  1  buffer select; also clears frame_valid in the buffer
buf_rd  out  1  buffer read strobe
buf_addr  out  8  buffer word address = byte pointer >> 2
buf_data  in  32  buffer read data, valid one cycle after buf_rd & buf_select
out_byte  out  8  streamed frame byte
out_valid  out  1  out_byte valid
out_ready  in  1  consumer accepts byte when out_valid & out_ready
out_last  out  1  marks final byte of frame, qualified by out_valid
abort  in  1  synchronous; abandon current frame, return to IDLE
busy  out  1  high in every state except IDLE
drop_cnt  out  8  frames dropped (zero length or > MAX_LEN), saturating
ovr_cnt  out  8  frame_valid rising edges seen while busy, saturating

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; buf_select, buf_rd, out_valid, out_last, busy = 0; buf_addr, out_byte = 0; drop_cnt, ovr_cnt = 0; sync flops = 0.
- frame_valid goes through a 2-flop synchroniser and then a rising-edge detector. The synchronised rising edge is the only trigger.
- len = (frame_end - frame_start) mod BUF_BYTES, computed CNT_WIDTH bits wide so wrap-around is implicit. ptr = frame_start[CNT_WIDTH-1:0].
- States and transitions:
  - IDLE -> CLEAR on edge. Latch ptr and len.
  - CLEAR: one cycle, buf_select=1, buf_rd=0; this clears the flag. If len==0 or len>MAX_LEN, increment drop_cnt and go to IDLE. Otherwise go to FETCH.
  - FETCH: one cycle, buf_select=buf_rd=1, buf_addr=ptr>>2. Next state is WAIT.
  - WAIT: capture buf_data into a word register, then go to STREAM. Fetch-to-first-byte latency is 2 cycles.
  - STREAM: out_valid=1; out_byte = word lane ptr[1:0] (lane 0 = bits 7:0); out_last=1 when remaining==1. On accept, ptr<=ptr+1 mod BUF_BYTES and remaining<=remaining-1.
    - If remaining==1: go to IDLE.
    - Else if the new ptr[1:0]==0: go to FETCH.
    - Else stay in STREAM.
  - While out_ready is low, out_byte, out_valid and out_last stay stable.
- Wrap: ptr BUF_BYTES-1 -> 0, and buf_addr follows. A frame that straddles the end of the buffer streams contiguously.
- A frame_valid edge while busy increments ovr_cnt and is otherwise ignored. Both counters saturate at 255.
- abort has priority over every transition. Next cycle: IDLE, out_valid=0, no count changes.
- buf_select is asserted only in CLEAR and FETCH. It never overlaps with out_valid's first cycle of a word, so there is no read-while-stream hazard.

Optional Feature:
STRIP_FCS_EN. When defined, the 2 trailing FCS bytes are excluded:
- effective len = len-2;
- frames with len<=2 count as drops;
- out_last falls on the last payload byte.
When undefined, all len bytes stream, FCS included.

Test Plan:
- start=0x10, end=0x16, words preloaded 0x44332211, 0x88776655 at addr 4/5, out_ready=1 -> bytes 11 22 33 44 55 66; out_last on 66; exactly one CLEAR pulse; FETCH at addr 4 then 5.
- start=0x1FE, end=0x002 (wrap) -> 4 bytes from word 0x7F lanes 2,3 then word 0 lanes 0,1; buf_addr 0x7F then 0x00.
- start=end=0x40 -> CLEAR pulse, no out_valid, drop_cnt=1; len 300 -> drop_cnt=2.
- out_ready toggled 1,0,0,1 mid-word -> out_byte held through stall; no extra buf_rd.
- Second frame_valid edge during a streaming frame -> ovr_cnt=1 and current frame completes intact; abort mid-frame -> IDLE next cycle, busy=0.
- With STRIP_FCS_EN, len=6 -> 4 bytes with out_last on the 4th; len=2 -> drop_cnt increments.

Source files
------------

// File: rtl/econet_rx_frame_reader.sv
// econet_rx_frame_reader
// Reads a good frame out of the circular Econet receive buffer and streams it
// as bytes with a valid/ready handshake. It also clears the buffer's
// frame-valid flag and keeps saturating drop and overrun counters.
//
// Optional build macro: STRIP_FCS_EN. When it is defined, the two trailing FCS
// bytes are not streamed, and frames of two bytes or fewer are dropped.
//
// Ports:
//   sys_clk, reset_n        clock and asynchronous active-low reset
//   frame_valid             good-frame level from the econet_clk domain
//   frame_start/frame_end   frame byte bounds in the buffer (low CNT_WIDTH bits)
//   buf_select/buf_rd       buffer port select (clears the flag) and read strobe
//   buf_addr/buf_data       buffer word address and read data (1-cycle latency)
//   out_byte/out_valid/
//   out_ready/out_last      byte stream to the consumer
//   abort                   abandon the current frame
//   busy                    high in every state except IDLE
//   drop_cnt/ovr_cnt        saturating drop and overrun counters
module econet_rx_frame_reader #(
    parameter int unsigned BUF_BYTES = 512,
    parameter int unsigned CNT_WIDTH = 9,
    parameter int unsigned MAX_LEN   = 256
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        frame_valid,
    input  logic [31:0] frame_start,
    input  logic [31:0] frame_end,
    output logic        buf_select,
    output logic        buf_rd,
    output logic [7:0]  buf_addr,
    input  logic [31:0] buf_data,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    input  logic        abort,
    output logic        busy,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  ovr_cnt
);

    localparam logic [CNT_WIDTH-1:0] PTR_MASK = CNT_WIDTH'(BUF_BYTES - 1);
`ifdef STRIP_FCS_EN
    localparam logic [CNT_WIDTH-1:0] FCS_LEN  = CNT_WIDTH'(2);
`else
    localparam logic [CNT_WIDTH-1:0] FCS_LEN  = CNT_WIDTH'(0);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        WAIT   = 3'd3,
        STREAM = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   fv_meta_q, fv_sync_q, fv_prev_q;
    logic [CNT_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [31:0]            word_q, word_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic [7:0]             ovr_cnt_q, ovr_cnt_d;
    logic                   buf_select_q, buf_select_d;
    logic                   buf_rd_q, buf_rd_d;
    logic [7:0]             buf_addr_q, buf_addr_d;
    logic [7:0]             out_byte_q, out_byte_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;

    logic                   fv_rise_c;
    logic                   accept_c;
    logic                   drop_c;
    logic [CNT_WIDTH-1:0]   len_raw_c;
    logic [CNT_WIDTH-1:0]   ptr_inc_c;
    logic                   unused_c;

    // Only the low CNT_WIDTH bits of the frame bounds address the buffer.
    assign unused_c = ^{frame_start[31:CNT_WIDTH], frame_end[31:CNT_WIDTH]};

    // Byte lane extraction, lane 0 = bits 7:0.
    function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] s);
        logic [7:0] b;
        unique case (s)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign fv_rise_c = fv_sync_q & ~fv_prev_q;
    assign accept_c  = (state_q == STREAM) & out_valid_q & out_ready;
    // Modular subtraction makes buffer wrap-around implicit.
    assign len_raw_c = (frame_end[CNT_WIDTH-1:0] - frame_start[CNT_WIDTH-1:0]) & PTR_MASK;
    assign ptr_inc_c = (ptr_q + CNT_WIDTH'(1)) & PTR_MASK;

`ifdef STRIP_FCS_EN
    assign drop_c = (len_q <= CNT_WIDTH'(2)) || (32'(len_q) > MAX_LEN);
`else
    assign drop_c = (len_q == '0) || (32'(len_q) > MAX_LEN);
`endif

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        word_d     = word_q;
        drop_cnt_d = drop_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        out_byte_d = out_byte_q;

        unique case (state_q)
            IDLE: begin
                if (fv_rise_c) begin
                    ptr_d   = frame_start[CNT_WIDTH-1:0];
                    len_d   = len_raw_c;
                    rem_d   = len_raw_c - FCS_LEN;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (drop_c) begin
                    if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                word_d     = buf_data;
                out_byte_d = lane_sel(buf_data, ptr_q[1:0]);
                state_d    = STREAM;
            end
            STREAM: begin
                if (accept_c) begin
                    ptr_d = ptr_inc_c;
                    rem_d = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_d = IDLE;
                    end else if (ptr_inc_c[1:0] == 2'b00) begin
                        state_d = FETCH;
                    end else begin
                        out_byte_d = lane_sel(word_q, ptr_inc_c[1:0]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new frame while one is in flight is only counted.
        if (fv_rise_c && (state_q != IDLE) && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end

        if (abort) begin
            state_d    = IDLE;
            drop_cnt_d = drop_cnt_q;
            ovr_cnt_d  = ovr_cnt_q;
        end

        // Outputs are registered from the next state so they align with state_q.
        buf_select_d = (state_d == CLEAR) || (state_d == FETCH);
        buf_rd_d     = (state_d == FETCH);
        buf_addr_d   = (state_d == FETCH) ? 8'(ptr_d >> 2) : buf_addr_q;
        out_valid_d  = (state_d == STREAM);
        out_last_d   = (state_d == STREAM) && (rem_d == CNT_WIDTH'(1));
        busy_d       = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fv_meta_q    <= 1'b0;
            fv_sync_q    <= 1'b0;
            fv_prev_q    <= 1'b0;
            ptr_q        <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            word_q       <= '0;
            drop_cnt_q   <= '0;
            ovr_cnt_q    <= '0;
            buf_select_q <= 1'b0;
            buf_rd_q     <= 1'b0;
            buf_addr_q   <= '0;
            out_byte_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fv_meta_q    <= frame_valid;
            fv_sync_q    <= fv_meta_q;
            fv_prev_q    <= fv_sync_q;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            word_q       <= word_d;
            drop_cnt_q   <= drop_cnt_d;
            ovr_cnt_q    <= ovr_cnt_d;
            buf_select_q <= buf_select_d;
            buf_rd_q     <= buf_rd_d;
            buf_addr_q   <= buf_addr_d;
            out_byte_q   <= out_byte_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
        end
    end

    assign buf_select = buf_select_q;
    assign buf_rd     = buf_rd_q;
    assign buf_addr   = buf_addr_q;
    assign out_byte   = out_byte_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_cnt_q;
    assign ovr_cnt    = ovr_cnt_q;

endmodule
